// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and helpers for the 1x3 router sync stage
package router_pkg;

    localparam int NUM_PORTS       = 3;
    localparam int ADDR_W          = 2;
    localparam int TIMEOUT_DEFAULT = 30;
    localparam int CNT_W_DEFAULT   = 5;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    // One-hot port select; the invalid address selects nothing.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [ADDR_W-1:0] addr);
        if (addr == ADDR_INVALID)
            return '0;
        return NUM_PORTS'(1) << addr;
    endfunction

endpackage

// File: rtl/router_sync_if.sv
// rtl/router_sync_if.sv - FSM/FIFO side signal bundle of the router sync stage
interface router_sync_if;

    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       full_0, full_1, full_2;
    logic       empty_0, empty_1, empty_2;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    modport slave (
        input  detect_add, data_in, write_enb_reg,
        input  full_0, full_1, full_2,
        input  empty_0, empty_1, empty_2,
        input  read_enb_0, read_enb_1, read_enb_2,
        output write_enb, fifo_full,
        output vld_out_0, vld_out_1, vld_out_2,
        output soft_reset_0, soft_reset_1, soft_reset_2
    );

    modport master (
        output detect_add, data_in, write_enb_reg,
        output full_0, full_1, full_2,
        output empty_0, empty_1, empty_2,
        output read_enb_0, read_enb_1, read_enb_2,
        input  write_enb, fifo_full,
        input  vld_out_0, vld_out_1, vld_out_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2
    );

endinterface

// File: rtl/router_sync_wdog.sv
// rtl/router_sync_wdog.sv - per-port stall watchdog issuing a one-cycle FIFO flush
module router_sync_wdog #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic vld,
    input  logic read_enb,
    output logic soft_reset
);

    logic [CNT_W-1:0] cnt;

    // The pulse cycle itself clears the counter, so a still-stalled port re-arms from zero.
    always_ff @(posedge clk) begin
        if (reset || !vld || read_enb) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            cnt        <= '0;
            soft_reset <= 1'b1;
        end else begin
            cnt        <= cnt + 1'b1;
            soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_sync.sv
// rtl/router_sync.sv - header address latch, write steering and per-port watchdogs
module router_sync
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    router_sync_if.slave  bus
);

    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (reset)
            addr_q <= '0;
        else if (bus.detect_add)
            addr_q <= bus.data_in;
    end

    // Steering uses the registered address, so a header-cycle write still goes to the old port.
    assign bus.write_enb = bus.write_enb_reg ? port_onehot(addr_q) : '0;

    always_comb begin
        bus.fifo_full = 1'b0;
        case (addr_q)
            2'd0:    bus.fifo_full = bus.full_0;
            2'd1:    bus.fifo_full = bus.full_1;
            2'd2:    bus.fifo_full = bus.full_2;
            default: bus.fifo_full = 1'b0;
        endcase
    end

    assign bus.vld_out_0 = ~bus.empty_0;
    assign bus.vld_out_1 = ~bus.empty_1;
    assign bus.vld_out_2 = ~bus.empty_2;

    router_sync_wdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog_0 (
        .clk        (clk),
        .reset      (reset),
        .vld        (bus.vld_out_0),
        .read_enb   (bus.read_enb_0),
        .soft_reset (bus.soft_reset_0)
    );

    router_sync_wdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog_1 (
        .clk        (clk),
        .reset      (reset),
        .vld        (bus.vld_out_1),
        .read_enb   (bus.read_enb_1),
        .soft_reset (bus.soft_reset_1)
    );

    router_sync_wdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog_2 (
        .clk        (clk),
        .reset      (reset),
        .vld        (bus.vld_out_2),
        .read_enb   (bus.read_enb_2),
        .soft_reset (bus.soft_reset_2)
    );

endmodule

// File: tb/tb_router_sync.sv
// tb/tb_router_sync.sv - directed vector and watchdog sequence bench for router_sync
module tb_router_sync;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    router_sync_if bus ();

    router_sync dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       detect_add;
        logic [1:0] data_in;
        logic       write_enb_reg;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] exp_write_enb;
        logic       exp_fifo_full;
        logic [2:0] exp_vld;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.detect_add    = v.detect_add;
        bus.data_in       = v.data_in;
        bus.write_enb_reg = v.write_enb_reg;
        {bus.full_2, bus.full_1, bus.full_0}    = v.full;
        {bus.empty_2, bus.empty_1, bus.empty_0} = v.empty;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        reset = 1'b0;
        bus.detect_add    = 1'b0;
        bus.write_enb_reg = 1'b0;
        {bus.empty_2, bus.empty_1, bus.empty_0}          = 3'b111;
        {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0} = 3'b000;
    endtask

    // Port 1 stalls from cycle 1; pulses are expected in cycles p1 and p2 only.
    task automatic stall(input string name, input int ncyc, input int read_cyc,
                         input int rst_cyc, input int p1, input int p2);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            {bus.empty_2, bus.empty_1, bus.empty_0} = 3'b101;
            bus.read_enb_1 = (c == read_cyc);
            reset          = (c == rst_cyc);
            #1;
            chk({name, " soft_reset_1"}, int'(bus.soft_reset_1), int'(c == p1 || c == p2));
            chk({name, " soft_reset_0"}, int'(bus.soft_reset_0), 0);
            chk({name, " soft_reset_2"}, int'(bus.soft_reset_2), 0);
        end
        idle_cycle();
    endtask

    initial begin
        errors = 0;
        checks = 0;

        //       det  din    wer   full    empty   exp_we  ff    vld
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 3'b100, 3'b111, 3'b100, 1'b1, 3'b000};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 3'b011, 3'b111, 3'b100, 1'b0, 3'b000};
        vecs[3]  = '{1'b1, 2'd3, 1'b0, 3'b111, 3'b111, 3'b000, 1'b1, 3'b000};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000};
        vecs[5]  = '{1'b1, 2'd1, 1'b1, 3'b000, 3'b101, 3'b000, 1'b0, 3'b010};
        vecs[6]  = '{1'b1, 2'd0, 1'b1, 3'b010, 3'b111, 3'b010, 1'b1, 3'b000};
        vecs[7]  = '{1'b0, 2'd0, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 3'b000};
        vecs[8]  = '{1'b0, 2'd0, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 3'b111};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 3'b000, 3'b110, 3'b000, 1'b0, 3'b001};
        vecs[10] = '{1'b0, 2'd0, 1'b1, 3'b100, 3'b111, 3'b100, 1'b1, 3'b000};

        reset = 1'b1;
        bus.detect_add    = 1'b0;
        bus.data_in       = 2'd0;
        bus.write_enb_reg = 1'b1;
        {bus.full_2, bus.full_1, bus.full_0}             = 3'b000;
        {bus.empty_2, bus.empty_1, bus.empty_0}          = 3'b111;
        {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0} = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset write_enb", int'(bus.write_enb), 1);
        chk("reset soft_reset", int'({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}), 0);
        chk("reset vld_out", int'({bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}), 0);
        bus.full_0 = 1'b1;
        #1;
        chk("reset fifo_full follows full_0", int'(bus.fifo_full), 1);
        reset = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.full_0 = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d write_enb", i), int'(bus.write_enb), int'(vecs[i].exp_write_enb));
            chk($sformatf("vec%0d fifo_full", i), int'(bus.fifo_full), int'(vecs[i].exp_fifo_full));
            chk($sformatf("vec%0d vld_out", i),
                int'({bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}), int'(vecs[i].exp_vld));
            chk($sformatf("vec%0d soft_reset", i),
                int'({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}), 0);
        end
        idle_cycle();
        idle_cycle();

        stall("timeout", 62, 0, 0, 31, 61);
        stall("read_restart", 55, 20, 0, 51, 0);
        stall("mid_reset", 60, 0, 25, 56, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
